sum_uart_tx: RTL and testbench

Buffered UART transmitter that consumes the 8-bit sums produced by the adder stage and serializes them onto a single output pin as 8N1 frames. It sits directly downstream of the adder inside the Team11 tile. It absorbs bursts in a small FIFO so the adder side sees only a valid/ready handshake. The serial line goes to a dedicated output pin for observation by the board-level UART.

---
 rtl/sum_uart_tx_if.sv | 9 +
 rtl/sum_uart_tx.sv | 142 ++++++++++++++
 tb/tb_sum_uart_tx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sum_uart_tx_if.sv
// Byte handshake between the adder stage (master) and the UART transmitter (slave).
interface sum_uart_tx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/sum_uart_tx.sv
// Buffered 8N1 UART transmitter: a small FIFO absorbs adder bursts and an
// IDLE/START/DATA/STOP FSM serializes each byte LSB first onto a registered tx.
module sum_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    sum_uart_tx_if.slave                  in_if,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0]   BAUD_MAX = 16'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                         state_q, state_d;
    logic [15:0]                    baud_q, baud_d;
    logic [2:0]                     bit_q, bit_d;
    logic [7:0]                     shift_q, shift_d;
    logic                           tx_q, tx_d;
    logic [AW-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                  count_q, count_d;
    logic [FIFO_DEPTH-1:0][7:0]     mem_q, mem_d;

    logic push, pop, baud_end, have_data;

    assign in_if.in_ready = (count_q != FULL_CNT);
    assign tx             = tx_q;
    assign busy           = (state_q != IDLE);
    assign fifo_count     = count_q;
    assign have_data      = (count_q != '0);
    assign baud_end       = (baud_q == BAUD_MAX);
    assign push           = in_if.in_valid && in_if.in_ready;

    // Frame sequencing; pop is asserted only when leaving IDLE or at the last STOP cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (have_data) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    bit_d   = '0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (have_data) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        bit_d   = '0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // tx follows the next state so the pin is a plain flop output.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_if.in_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_sum_uart_tx.sv
// Directed bench for sum_uart_tx: reset, single frame, burst fill, push/pop
// overlap, wrap-around with gapped producer, and idle line behaviour.
module tb_sum_uart_tx;
    logic       clk;
    logic       rst;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    sum_uart_tx_if ifc ();

    sum_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_if      (ifc.slave),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] src_q[$];
    logic       gaps = 1'b0;
    logic [2:0] cnt_hist [40];
    logic       rdy_hist [40];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present the queue head; a byte already offered is held until accepted.
    task automatic drive();
        if (!ifc.in_valid && src_q.size() > 0) begin
            ifc.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            ifc.in_data  = src_q[0];
        end
    endtask

    task automatic step();
        logic acc;
        acc = ifc.in_valid && ifc.in_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            void'(src_q.pop_front());
            ifc.in_valid = 1'b0;
        end
        drive();
        chk("fifo_bound", 32'(fifo_count <= 3'd4), 32'd1);
    endtask

    // Starting at the first START-bit cycle, check all 40 line cycles of one frame.
    task automatic check_frame(input logic [7:0] b, input string tag,
                               input int inj_at, input logic [7:0] inj_b);
        logic exp_bit;
        int   bi;
        for (int k = 0; k < 40; k++) begin
            bi = k / 4;
            if (bi == 0)      exp_bit = 1'b0;
            else if (bi == 9) exp_bit = 1'b1;
            else              exp_bit = b[bi-1];
            cnt_hist[k] = fifo_count;
            rdy_hist[k] = ifc.in_ready;
            chk($sformatf("%s_bit%0d_c%0d", tag, bi, k % 4), 32'(tx), 32'(exp_bit));
            if (k == inj_at) begin
                src_q.push_back(inj_b);
                drive();
            end
            step();
        end
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 300) begin
            step();
            n++;
        end
        chk({tag, "_start_seen"}, 32'(tx), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(ifc.in_ready), 32'd1);
        chk("rst_count", 32'(fifo_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single byte 0xA5
        src_q.push_back(8'hA5);
        drive();
        step();
        chk("a5_wr_count", 32'(fifo_count), 32'd1);
        chk("a5_wr_busy", 32'(busy), 32'd0);
        chk("a5_wr_tx", 32'(tx), 32'd1);
        step();
        chk("a5_pop_busy", 32'(busy), 32'd1);
        chk("a5_pop_count", 32'(fifo_count), 32'd0);
        check_frame(8'hA5, "a5", -1, 8'h00);
        chk("a5_done_busy", 32'(busy), 32'd0);
        chk("a5_done_tx", 32'(tx), 32'd1);

        // Burst fill 0x01..0x06
        for (int i = 1; i <= 6; i++) src_q.push_back(8'(i));
        drive();
        step();
        chk("burst_e0_count", 32'(fifo_count), 32'd1);
        chk("burst_e0_busy", 32'(busy), 32'd0);
        step();
        chk("burst_e1_busy", 32'(busy), 32'd1);
        chk("burst_e1_count", 32'(fifo_count), 32'd1);
        check_frame(8'h01, "burst01", -1, 8'h00);
        chk("burst_e4_count", 32'(cnt_hist[3]), 32'd4);
        chk("burst_e4_ready", 32'(rdy_hist[3]), 32'd0);
        chk("burst_stop_ready", 32'(rdy_hist[39]), 32'd0);
        chk("burst_pop_ready", 32'(ifc.in_ready), 32'd1);
        chk("burst_pop_count", 32'(fifo_count), 32'd3);
        for (int i = 2; i <= 6; i++)
            check_frame(8'(i), $sformatf("burst%02x", i), -1, 8'h00);
        chk("burst_end_busy", 32'(busy), 32'd0);
        chk("burst_end_count", 32'(fifo_count), 32'd0);

        // Write coincides with STOP-end pop while two bytes are queued
        src_q.push_back(8'h31);
        src_q.push_back(8'h32);
        src_q.push_back(8'h33);
        drive();
        step();
        step();
        chk("pp_first_count", 32'(fifo_count), 32'd1);
        check_frame(8'h31, "pp31", 39, 8'h34);
        chk("pp_pre_count", 32'(cnt_hist[39]), 32'd2);
        chk("pp_post_count", 32'(fifo_count), 32'd2);
        check_frame(8'h32, "pp32", -1, 8'h00);
        check_frame(8'h33, "pp33", -1, 8'h00);
        check_frame(8'h34, "pp34", -1, 8'h00);
        chk("pp_end_busy", 32'(busy), 32'd0);

        // Wrap-around with a gapped producer
        gaps = 1'b1;
        for (int i = 0; i < 12; i++) src_q.push_back(8'h10 + 8'(i));
        drive();
        for (int i = 0; i < 12; i++) begin
            wait_start($sformatf("wrap%0d", i));
            check_frame(8'h10 + 8'(i), $sformatf("wrap%02x", 8'h10 + i), -1, 8'h00);
        end
        gaps = 1'b0;
        chk("wrap_end_busy", 32'(busy), 32'd0);

        // Reset mid-frame of 0x3C with another byte buffered
        src_q.push_back(8'h3C);
        src_q.push_back(8'h3D);
        drive();
        repeat (15) step();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(ifc.in_ready), 32'd1);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        src_q.delete();
        ifc.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle line after reset
        for (int i = 0; i < 200; i++) begin
            step();
            chk("idle_tx", 32'(tx), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_count", 32'(fifo_count), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
